// File: rtl/s_cpu_pkg.sv
// Shared S-CPU/APU types: ARAM slot owner tags and ARAM bus widths.
package s_cpu_pkg;

  typedef enum logic [1:0] {
    AO_NONE,
    AO_DSP,
    AO_CPU,
    AO_DBG
  } aram_owner_type;

  localparam int ARAM_AW = 16;
  localparam int ARAM_DW = 8;

endpackage

// File: rtl/s_aram_slot_timer.sv
// Free-running ARAM frame slot counter with slot-kind decode; zero latency decode, no backpressure.
module s_aram_slot_timer #(
  parameter  int SLOT_CNT  = 4,
  parameter  int DSP_SLOTS = 1,
  localparam int SLOT_W    = $clog2(SLOT_CNT)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              frame_start_o,
  output logic              dsp_slot_o,
  output logic              cpu_slot_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  // SLOT_CNT is a power of two, so the natural overflow is the frame wrap.
  assign slot_d = slot_q + SLOT_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o        = slot_q;
  assign frame_start_o = (slot_q == '0);
  assign dsp_slot_o    = (slot_q < SLOT_W'(DSP_SLOTS));
  assign cpu_slot_o    = (slot_q == SLOT_W'(SLOT_CNT - 1));

endmodule

// File: rtl/s_aram_arbiter.sv
// Time-division ARAM arbiter: fixed slot frame, one owner per cycle, read/cpu_en return 1 cycle after grant.
// No backpressure: requesters hold until granted. Debug/loader port and cpu_halt enabled by S_ARAM_DBG_EN.
module s_aram_arbiter
  import s_cpu_pkg::*;
#(
  parameter  int SLOT_CNT  = 4,
  parameter  int DSP_SLOTS = 1,
  localparam int SLOT_W    = $clog2(SLOT_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_access,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic [7:0]        cpu_rdata,
  input  logic              dsp_req,
  input  logic [15:0]       dsp_addr,
  input  logic [7:0]        dsp_wdata,
  input  logic              dsp_we,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [7:0]        dsp_rdata,
  input  logic              dbg_req,
  input  logic [15:0]       dbg_addr,
  input  logic [7:0]        dbg_wdata,
  input  logic              dbg_we,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [7:0]        dbg_rdata,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_start,
  output logic [15:0]       ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  logic           dsp_slot, cpu_slot;
  aram_owner_type owner;
  aram_owner_type tag_q, tag_d;

  s_aram_slot_timer #(
    .SLOT_CNT (SLOT_CNT),
    .DSP_SLOTS(DSP_SLOTS)
  ) u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .slot_o       (slot),
    .frame_start_o(frame_start),
    .dsp_slot_o   (dsp_slot),
    .cpu_slot_o   (cpu_slot)
  );

  // Owner is gated by reset so a write in the cycle reset rises never reaches the RAM.
  always_comb begin
    owner = AO_NONE;
    if (!reset) begin
      if (dsp_slot) begin
        if (dsp_req) begin
          owner = AO_DSP;
`ifdef S_ARAM_DBG_EN
        end else if (dbg_req) begin
          owner = AO_DBG;
`endif
        end
      end else if (cpu_slot) begin
`ifdef S_ARAM_DBG_EN
        if (!cpu_halt) begin
          owner = AO_CPU;
        end else if (dbg_req) begin
          owner = AO_DBG;
        end
`else
        owner = AO_CPU;
`endif
`ifdef S_ARAM_DBG_EN
      end else if (dbg_req) begin
        owner = AO_DBG;
`endif
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (owner)
      AO_DSP: begin
        ram_addr  = dsp_addr;
        ram_wdata = dsp_wdata;
        ram_we    = dsp_we;
      end
      AO_CPU: begin
        // Internal (non-access) CPU steps still burn the slot as a harmless read.
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we & cpu_access;
      end
`ifdef S_ARAM_DBG_EN
      AO_DBG: begin
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
        ram_we    = dbg_we;
      end
`endif
      default: ;
    endcase
  end

  assign tag_d = owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= AO_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign dsp_gnt    = (owner == AO_DSP);
  assign cpu_en     = (tag_q == AO_CPU);
  assign dsp_rvalid = (tag_q == AO_DSP);
  assign cpu_rdata  = ram_rdata;
  assign dsp_rdata  = ram_rdata;

`ifdef S_ARAM_DBG_EN
  assign dbg_gnt    = (owner == AO_DBG);
  assign dbg_rvalid = (tag_q == AO_DBG);
  assign dbg_rdata  = ram_rdata;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_addr, dbg_wdata, dbg_we, cpu_halt};
  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = '0;
`endif

endmodule

// File: tb/tb_s_aram_arbiter.sv
// Randomized scoreboard bench for s_aram_arbiter with a frame-level reference model and ARAM model.
module tb_s_aram_arbiter;
  import s_cpu_pkg::*;

  localparam int SLOT_CNT  = 4;
  localparam int DSP_SLOTS = 1;
`ifdef S_ARAM_DBG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we, cpu_access, cpu_halt;
  logic        cpu_en;
  logic [7:0]  cpu_rdata;
  logic        dsp_req;
  logic [15:0] dsp_addr;
  logic [7:0]  dsp_wdata;
  logic        dsp_we, dsp_gnt, dsp_rvalid;
  logic [7:0]  dsp_rdata;
  logic        dbg_req;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_we, dbg_gnt, dbg_rvalid;
  logic [7:0]  dbg_rdata;
  logic [1:0]  slot;
  logic        frame_start;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  s_aram_arbiter #(.SLOT_CNT(SLOT_CNT), .DSP_SLOTS(DSP_SLOTS)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_access(cpu_access),
    .cpu_halt(cpu_halt), .cpu_en(cpu_en), .cpu_rdata(cpu_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata), .dsp_we(dsp_we),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .slot(slot), .frame_start(frame_start),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // ARAM macro stand-in and the model's own view of memory contents
  logic [7:0] aram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (ram_we) aram[ram_addr] <= ram_wdata;
    ram_rdata <= aram[ram_addr];
  end

  typedef struct {
    aram_owner_type who;
    int             cyc;
    bit             rd;
    logic [7:0]     data;
  } resp_t;

  resp_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc;
  logic  cpu_en_seen = 1'b0, dsp_gnt_seen = 1'b0, dbg_gnt_seen = 1'b0;
  logic [1:0]  slot_seen = 2'd0;
  logic [15:0] pool [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Cycles since reset release; cycle 0 is the first slot-0 cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference model: decides the slot owner from the frame position and request rules.
  always @(negedge clk) begin : model
    int             s;
    aram_owner_type eo;
    logic [15:0]    ea;
    logic [7:0]     ed;
    logic           ewe;
    resp_t          r;
    if (reset) begin
      chk("rst_slot", 32'(slot), 0);
      chk("rst_dsp_gnt", 32'(dsp_gnt), 0);
      chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      sb_q.delete();
    end else begin
      s  = cyc % SLOT_CNT;
      eo = AO_NONE;
      if (s < DSP_SLOTS) begin
        if (dsp_req)                eo = AO_DSP;
        else if (DBG_EN && dbg_req) eo = AO_DBG;
      end else if (s == SLOT_CNT - 1) begin
        if (!DBG_EN || !cpu_halt)   eo = AO_CPU;
        else if (dbg_req)           eo = AO_DBG;
      end else if (DBG_EN && dbg_req) begin
        eo = AO_DBG;
      end
      ea = 16'h0; ed = 8'h0; ewe = 1'b0;
      case (eo)
        AO_DSP: begin ea = dsp_addr; ed = dsp_wdata; ewe = dsp_we; end
        AO_CPU: begin ea = cpu_addr; ed = cpu_wdata; ewe = cpu_we && cpu_access; end
        AO_DBG: begin ea = dbg_addr; ed = dbg_wdata; ewe = dbg_we; end
        default: ;
      endcase
      chk("slot", 32'(slot), s);
      chk("frame_start", 32'(frame_start), 32'(s == 0));
      chk("dsp_gnt", 32'(dsp_gnt), 32'(eo == AO_DSP));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(eo == AO_DBG));
      chk("ram_addr", 32'(ram_addr), 32'(ea));
      chk("ram_wdata", 32'(ram_wdata), 32'(ed));
      chk("ram_we", 32'(ram_we), 32'(ewe));
      if (eo != AO_NONE) begin
        r.who  = eo;
        r.cyc  = cyc;
        r.rd   = !ewe && (eo != AO_CPU || cpu_access);
        r.data = ref_mem[ea];
        if (ewe) ref_mem[ea] = ed;
        sb_q.push_back(r);
      end
    end
    cpu_en_seen  = cpu_en;
    dsp_gnt_seen = dsp_gnt;
    dbg_gnt_seen = dbg_gnt;
    slot_seen    = slot;
  end

  // Monitor: pops the response due this cycle and compares strobes and read data.
  always @(negedge clk) begin : monitor
    resp_t          r;
    aram_owner_type w;
    w    = AO_NONE;
    r.rd = 1'b0;
    if (reset) begin
      chk("rst_cpu_en", 32'(cpu_en), 0);
      chk("rst_dsp_rvalid", 32'(dsp_rvalid), 0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    end else begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc - 1) begin
        r = sb_q.pop_front();
        w = r.who;
      end
      chk("cpu_en", 32'(cpu_en), 32'(w == AO_CPU));
      chk("dsp_rvalid", 32'(dsp_rvalid), 32'(w == AO_DSP));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(w == AO_DBG));
      if (r.rd) begin
        case (w)
          AO_CPU:  chk("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
          AO_DSP:  chk("dsp_rdata", 32'(dsp_rdata), 32'(r.data));
          AO_DBG:  chk("dbg_rdata", 32'(dbg_rdata), 32'(r.data));
          default: ;
        endcase
      end
`ifndef S_ARAM_DBG_EN
      chk("dbg_rdata_off", 32'(dbg_rdata), 0);
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    return pool[$urandom_range(7)];
  endfunction

  task automatic cpu_step(input logic [15:0] a, input logic w, input logic [7:0] d, input logic acc);
    int n;
    cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_access = acc;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!cpu_en_seen && n < 3 * SLOT_CNT);
    chk("cpu_step_done", 32'(cpu_en_seen), 1);
  endtask

  task automatic drive(input int p_dsp, input int p_dbg, input int p_halt);
    if (cpu_en_seen) begin
      cpu_addr   = pick();
      cpu_wdata  = 8'($urandom);
      cpu_we     = ($urandom_range(2) == 0);
      cpu_access = ($urandom_range(3) != 0);
    end
    if (!dsp_req || dsp_gnt_seen) begin
      dsp_req   = ($urandom_range(99) < p_dsp);
      dsp_addr  = pick();
      dsp_wdata = 8'($urandom);
      dsp_we    = ($urandom_range(3) == 0);
    end
    if (!dbg_req || dbg_gnt_seen) begin
      dbg_req   = ($urandom_range(99) < p_dbg);
      dbg_addr  = pick();
      dbg_wdata = 8'($urandom);
      dbg_we    = ($urandom_range(1) == 0);
    end
    if ($urandom_range(9) == 0) cpu_halt = ($urandom_range(99) < p_halt);
  endtask

  initial begin
    int n;
    pool = '{16'h00F0, 16'h1234, 16'h0200, 16'h2000, 16'h0000, 16'hFFFF, 16'h0201, 16'h1235};
    for (int i = 0; i < 65536; i++) begin
      aram[i]    = 8'($urandom);
      ref_mem[i] = aram[i];
    end
    aram[16'h00F0]    = 8'hA5;
    ref_mem[16'h00F0] = 8'hA5;
    reset = 1'b1;
    cpu_addr = 16'h00F0; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_access = 1'b1; cpu_halt = 1'b0;
    dsp_req = 1'b0; dsp_addr = 16'h0; dsp_wdata = 8'h0; dsp_we = 1'b0;
    dbg_req = 1'b0; dbg_addr = 16'h0; dbg_wdata = 8'h0; dbg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Held CPU read of 0x00F0: cpu_en with 0xA5 at cycles 4, 8, 12
    repeat (14) cycle();
    cpu_step(16'h1234, 1'b1, 8'h5A, 1'b1);
    cpu_step(16'h1234, 1'b0, 8'h00, 1'b1);
    cpu_step(16'h1234, 1'b1, 8'hEE, 1'b0);
    cpu_step(16'h1234, 1'b0, 8'h00, 1'b1);

    for (int ph = 0; ph < 4; ph++) begin
      repeat (600) begin
        cycle();
        case (ph)
          0:       drive(50, 50, 0);
          1:       drive(90, 90, 50);
          2:       drive(0, 80, 70);
          default: drive(30, 30, 20);
        endcase
      end
    end

    // Reset pulsed in slot 2 while a DBG write is presented
    dsp_req = 1'b0; cpu_halt = 1'b0;
    if (!dbg_req || dbg_gnt_seen) dbg_req = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (slot_seen != 2'd1 && n < 2 * SLOT_CNT);
    chk("find_slot2", 32'(slot_seen), 1);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 8'h77;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_step(16'h0200, 1'b0, 8'h00, 1'b1);
    repeat (8) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s_aram_arbiter.md
# s_aram_arbiter

Time-division arbiter and sequencer for the APU's single-port 64 KiB audio RAM, shared between the S-CPU, the S-DSP and an optional debug/loader port. It divides time into a fixed repeating frame of slots, grants each slot to exactly one requester, and generates the S-CPU `cpu_en` step strobe so the CPU advances exactly once per frame. It sits between `s_controller`/S-CPU datapath, the S-DSP and the ARAM macro.

## Interface
- `SLOT_CNT`, 4: slots per frame; power of two, ≥2.
- `DSP_SLOTS`, 1: slots 0..DSP_SLOTS-1 are DSP slots; must be ≤ SLOT_CNT-2.

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_addr` in 16, `cpu_wdata` in 8, `cpu_we` in 1, `cpu_access` in 1: CPU bus request for the current step; held stable until `cpu_en`.
- `cpu_halt` in 1: debug halt; CPU slot is withheld.
- `cpu_en` out 1: S-CPU step strobe.
- `cpu_rdata` out 8: read data, valid when `cpu_en`=1.
- `dsp_req` in 1, `dsp_addr` in 16, `dsp_wdata` in 8, `dsp_we` in 1: DSP request.
- `dsp_gnt` out 1, `dsp_rvalid` out 1, `dsp_rdata` out 8.
- `dbg_req` in 1, `dbg_addr` in 16, `dbg_wdata` in 8, `dbg_we` in 1: debug/loader request.
- `dbg_gnt` out 1, `dbg_rvalid` out 1, `dbg_rdata` out 8.
- `slot` out $clog2(SLOT_CNT): current slot index.
- `frame_start` out 1: high when `slot`==0.
- `ram_addr` out 16, `ram_wdata` out 8, `ram_we` out 1, `ram_rdata` in 8: ARAM port; synchronous read, data one cycle after address.

## Operation
- Slot counter increments every clock and wraps from SLOT_CNT-1 to 0. Slot kinds:
  - DSP slot: slot < DSP_SLOTS.
  - CPU slot: slot == SLOT_CNT-1.
  - Free slot: all other slots.
- Owner per cycle is combinational from slot and requests:
  - DSP slot: DSP if `dsp_req`, else DBG if `dbg_req`, else NONE. The CPU never uses a DSP slot.
  - Free slot: DBG if `dbg_req`, else NONE.
  - CPU slot: CPU if !`cpu_halt`, else DBG if `dbg_req`, else NONE.
- RAM port drive:
  - `ram_addr`/`ram_wdata` come from the owner; NONE drives 0.
  - `ram_we` = owner write enable. For the CPU this is `cpu_we & cpu_access`.
  - A CPU slot with `cpu_access`=0 is an internal cycle: read only, data ignored.
- `dsp_gnt`/`dbg_gnt` are high in the cycle their request is consumed. The requester holds `req`/addr/data until it sees the grant, then may change them on the next clock.
- Read return: registered owner tag one cycle later.
  - Tag CPU: `cpu_en`=1.
  - Tag DSP: `dsp_rvalid`=1.
  - Tag DBG: `dbg_rvalid`=1.
  - All three rdata outputs are direct copies of `ram_rdata`.
  - rvalid is also asserted after writes; requesters ignore it.
- Priority on simultaneous requests: DSP > DBG in DSP slots; CPU > DBG in the CPU slot unless halted.
- Halt takes effect at the next CPU slot. A `cpu_en` already scheduled still fires.

## Timing
- Reset values:
  - `slot`=0, owner tag = NONE.
  - `cpu_en`, `dsp_rvalid`, `dbg_rvalid` = 0.
  - While `reset` is high: `dsp_gnt`=`dbg_gnt`=`ram_we`=0, `ram_addr`=0.
- After reset release:
  - First clock edge is slot 0.
  - CPU slot falls at cycle SLOT_CNT-1; `cpu_en` pulses at cycle SLOT_CNT, then every SLOT_CNT cycles.
- Latency: grant to rvalid = 1 cycle. `cpu_en` duty = 1/SLOT_CNT.
- Reset asserted mid-frame:
  - Any write in that cycle is suppressed.
  - Pending rvalid/`cpu_en` are dropped.
  - Counter returns to 0.

## Configuration
- `S_ARAM_DBG_EN` defined: debug port is functional as above.
- `S_ARAM_DBG_EN` undefined:
  - Ports remain present.
  - `dbg_gnt`=`dbg_rvalid`=0, `dbg_rdata`=0.
  - `cpu_halt` is ignored; the CPU always owns the CPU slot.
  - DBG owner logic is removed.

## Structure
- In `s_cpu_pkg`: `aram_owner_type` enum {AO_NONE, AO_DSP, AO_CPU, AO_DBG}.
- Sub-module `s_aram_slot_timer`: slot counter, `frame_start`, slot-kind decode. The arbiter proper instantiates it.

## Test plan
All cases use SLOT_CNT=4, DSP_SLOTS=1.
- Reset release; CPU read `cpu_addr`=0x00F0, mem=0xA5 -> `ram_addr`=0x00F0 in cycles 3, 7, 11; `cpu_en` in cycles 4, 8, 12 with `cpu_rdata`=0xA5.
- CPU write 0x1234←0x5A, then read -> `ram_we` only in slot 3; next step's `cpu_rdata`=0x5A; `cpu_access`=0 steps give no `ram_we`.
- `dsp_req` held, addr 0x2000 -> `dsp_gnt` only in slot 0; `dsp_rvalid` in slot 1, every 4 cycles; `cpu_en` cadence unchanged.
- `dsp_req`+`dbg_req` in slot 0 -> DSP granted in slot 0, DBG granted in slot 1; DBG write 0x0200←0x33 is readable by the CPU afterward.
- `cpu_halt`=1 with `dbg_req` waiting in slot 3 -> `dbg_gnt` in slot 3, no `cpu_en`; release halt -> `cpu_en` resumes one frame later. Macro off -> `dbg_gnt` never asserts.
- `reset` pulsed during slot 2 with a DBG write -> no `ram_we`; `slot`=0 and `cpu_en`=0 after release.
